// File: rtl/syn_current_8b.sv
// Synapse stage for the 8-bit QIF neuron: weight lookup per spike event, saturating current.
// Define SYN_DECAY_EN to add the tick counter and exponential decay of the current.
module syn_current_8b #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned TICK_DIV    = 4,
  localparam int unsigned SW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spk_valid,
  input  logic [SW-1:0] spk_src,
  output logic          spk_ready,
  input  logic          w_we,
  input  logic [SW-1:0] w_addr,
  input  logic [7:0]    w_data,
  input  logic          sat_clr,
  output logic [7:0]    I_syn,
  output logic          sat
);

  if (TICK_DIV < 2) begin : g_chk_div
    $error("TICK_DIV must be at least 2");
  end
  if (DECAY_SHIFT > 8) begin : g_chk_shift
    $error("DECAY_SHIFT must not exceed 8");
  end

  typedef struct packed {
    logic       vld;
    logic [7:0] w;
  } stg_t;

  logic [7:0]        w_q [N_SRC];
  logic [7:0]        w_d [N_SRC];
  stg_t              stg_q, stg_d;
  logic [7:0]        acc_q, acc_d;
  logic              sat_q, sat_d;

  logic              accept;
  logic [7:0]        rd_w;
  logic signed [8:0] acc_ext;
  logic signed [8:0] base;
  logic signed [8:0] sum;
  logic              clamp;

  assign spk_ready = rst_n && !w_we;
  assign accept    = spk_valid && spk_ready;
  assign acc_ext   = {acc_q[7], acc_q};
  assign I_syn     = acc_q;
  assign sat       = sat_q;

  // Table read; sources with no table entry read as weight 0.
  always_comb begin
    rd_w = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (spk_src == SW'(i)) rd_w = w_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_d[i] = w_q[i];
      if (w_we && (w_addr == SW'(i))) w_d[i] = w_data;
    end
  end

`ifdef SYN_DECAY_EN
  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0]     tick_q, tick_d;
  logic              tick;
  logic [8:0]        mag;
  logic [8:0]        step;
  logic signed [8:0] dec;

  // Magnitude in 9 bits so -128 decays like +128.
  always_comb begin
    tick   = (tick_q == TW'(TICK_DIV - 1));
    tick_d = tick ? '0 : tick_q + TW'(1);
    mag    = acc_ext[8] ? $unsigned(-acc_ext) : $unsigned(acc_ext);
    step   = mag >> DECAY_SHIFT;
    if ((step == '0) && (mag != '0)) step = 9'd1;
    dec    = acc_ext[8] ? (acc_ext + $signed(step)) : (acc_ext - $signed(step));
    base   = tick ? dec : acc_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_d;
  end
`else
  assign base = acc_ext;
`endif

  // Decay happens first, then the staged weight is added and the result clamped.
  always_comb begin
    sum   = base + (stg_q.vld ? $signed({stg_q.w[7], stg_q.w}) : 9'sd0);
    acc_d = sum[7:0];
    clamp = 1'b0;
    if (sum > 9'sd127) begin
      acc_d = 8'h7f;
      clamp = 1'b1;
    end else if (sum < -9'sd128) begin
      acc_d = 8'h80;
      clamp = 1'b1;
    end
    sat_d = sat_q;
    if (sat_clr) sat_d = 1'b0;
    if (clamp)   sat_d = 1'b1;
    stg_d.vld = accept;
    stg_d.w   = accept ? rd_w : stg_q.w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SRC; i++) w_q[i] <= '0;
      stg_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      stg_q <= stg_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_syn_current_8b.sv
// Scoreboard bench for syn_current_8b: directed cycles push expectations, a monitor checks them.
module tb_syn_current_8b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spk_valid;
  logic [2:0] spk_src;
  logic       spk_ready;
  logic       w_we;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       sat_clr;
  logic [7:0] I_syn;
  logic       sat;

  syn_current_8b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spk_valid (spk_valid),
    .spk_src   (spk_src),
    .spk_ready (spk_ready),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .sat_clr   (sat_clr),
    .I_syn     (I_syn),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // msk[0]: check I_syn, msk[1]: check sat, msk[2]: check spk_ready
  typedef struct {
    string      nm;
    logic [2:0] msk;
    logic [7:0] ei;
    logic       es;
    logic       er;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  bit          stim_done = 1'b0;
  bit          run = 1'b1;
  int unsigned cycles = 0;

  task automatic cy(input logic rn, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                    input logic v, input logic [2:0] src, input logic clr,
                    input logic [2:0] msk, input logic [7:0] ei, input logic es,
                    input logic er, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n     = rn;
    w_we      = we;
    w_addr    = wa;
    w_data    = wd;
    spk_valid = v;
    spk_src   = src;
    sat_clr   = clr;
    x.nm = nm; x.msk = msk; x.ei = ei; x.es = es; x.er = er;
    sb_q.push_back(x);
  endtask

  task automatic chk_i(input int n, input logic [7:0] ei, input string nm);
    for (int i = 0; i < n; i++) cy(1, 0, 0, 0, 0, 0, 0, 3'b001, ei, 0, 0, nm);
  endtask

  task automatic ev(input logic [2:0] src, input logic [7:0] ei, input string nm);
    cy(1, 0, 0, 0, 1, src, 0, 3'b101, ei, 0, 1, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] ei, input string nm);
    cy(1, 1, a, d, 0, 0, 0, 3'b101, ei, 0, 0, nm);
  endtask

  initial begin : stim
    rst_n = 1'b0; spk_valid = 1'b1; spk_src = 3'd3;
    w_we = 1'b0; w_addr = '0; w_data = '0; sat_clr = 1'b0;
    // reset with an event pending, then a zero-weight event after release
    cy(0, 0, 0, 0, 1, 3, 0, 3'b111, 8'd0, 0, 0, "rst_hold0");
    cy(0, 0, 0, 0, 1, 3, 0, 3'b111, 8'd0, 0, 0, "rst_hold1");
    cy(1, 0, 0, 0, 1, 4, 0, 3'b101, 8'd0, 0, 1, "rst_release");
    chk_i(1, 8'd0, "zero_wt_a");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'd0, 0, 0, "zero_wt_b");
`ifdef SYN_DECAY_EN
    wr(0, 8'h40, 8'd0, "dk_wr");
    ev(0, 8'd0, "dk_ev");
    chk_i(1, 8'd0, "dk_lat");
    chk_i(2, 8'd64, "dk_64");
    chk_i(4, 8'd56, "dk_56");
    chk_i(4, 8'd49, "dk_49");
    chk_i(1, 8'd43, "dk_43");
    cy(0, 0, 0, 0, 0, 0, 0, 3'b101, 8'd43, 0, 0, "dk_rst");
    cy(1, 1, 0, 8'h40, 0, 0, 0, 3'b111, 8'd0, 0, 0, "dk_rst_clr");
    wr(1, 8'h0a, 8'd0, "tk_wr");
    ev(0, 8'd0, "tk_ev0");
    chk_i(1, 8'd0, "tk_lat");
    chk_i(2, 8'd64, "tk_64");
    ev(1, 8'd64, "tk_ev1");
    chk_i(1, 8'd64, "tk_hold");
    chk_i(1, 8'd66, "tk_add_on_tick");
    cy(0, 0, 0, 0, 0, 0, 0, 3'b001, 8'd66, 0, 0, "sm_rst");
    cy(1, 1, 2, 8'h05, 0, 0, 0, 3'b001, 8'd0, 0, 0, "sm_wr");
    ev(2, 8'd0, "sm_ev");
    chk_i(1, 8'd0, "sm_lat");
    chk_i(1, 8'd5, "sm_5");
    chk_i(4, 8'd4, "sm_4");
    chk_i(4, 8'd3, "sm_3");
    chk_i(4, 8'd2, "sm_2");
    chk_i(4, 8'd1, "sm_1");
    chk_i(8, 8'd0, "sm_0");
    wr(3, 8'hfb, 8'd0, "ng_wr");
    ev(3, 8'd0, "ng_ev");
    chk_i(1, 8'd0, "ng_lat");
    chk_i(1, 8'hfb, "ng_m5");
    chk_i(4, 8'hfc, "ng_m4");
    chk_i(4, 8'hfd, "ng_m3");
    chk_i(4, 8'hfe, "ng_m2");
    chk_i(4, 8'hff, "ng_m1");
    chk_i(4, 8'd0, "ng_0");
    wr(4, 8'h80, 8'd0, "mn_wr");
    ev(4, 8'd0, "mn_ev");
    chk_i(1, 8'd0, "mn_lat");
    chk_i(1, 8'h80, "mn_m128");
    chk_i(2, 8'h90, "mn_m112");
`else
    wr(5, 8'hf9, 8'd0, "ac_wr5");
    cy(1, 1, 2, 8'd20, 1, 2, 0, 3'b101, 8'd0, 0, 0, "wr_blocks_ev");
    ev(2, 8'd0, "ac_ev2");
    ev(5, 8'd0, "ac_ev5");
    chk_i(1, 8'd20, "ac_20");
    chk_i(1, 8'd13, "ac_13");
    cy(0, 0, 0, 0, 0, 0, 0, 3'b101, 8'd13, 0, 0, "st_rst");
    cy(1, 1, 0, 8'd100, 0, 0, 0, 3'b111, 8'd0, 0, 0, "st_wr0");
    wr(1, 8'h9c, 8'd0, "st_wr1");
    ev(0, 8'd0, "st_ev0a");
    ev(0, 8'd0, "st_ev0b");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'd100, 0, 0, "st_100");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'd127, 1, 0, "st_127");
    cy(1, 0, 0, 0, 0, 0, 1, 3'b011, 8'd127, 1, 0, "st_clr_pulse");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'd127, 0, 0, "st_cleared");
    ev(1, 8'd127, "sn_ev_a");
    ev(1, 8'd127, "sn_ev_b");
    ev(1, 8'd27, "sn_27");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'hb7, 0, 0, "sn_m73");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'h80, 1, 0, "sn_m128");
    cy(1, 0, 0, 0, 1, 1, 1, 3'b011, 8'h80, 1, 0, "sc_clr_ev");
    cy(1, 0, 0, 0, 0, 0, 1, 3'b011, 8'h80, 0, 0, "sc_clr_only");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'h80, 1, 0, "sc_set_wins");
    wr(3, 8'h1e, 8'h80, "mf_wr");
    ev(3, 8'h80, "mf_ev");
    cy(0, 0, 0, 0, 0, 0, 0, 3'b101, 8'h80, 0, 0, "mf_rst");
    cy(1, 0, 0, 0, 0, 0, 0, 3'b011, 8'd0, 0, 0, "mf_flushed");
    ev(3, 8'd0, "mf_ev_again");
    chk_i(2, 8'd0, "mf_tbl_clr");
`endif
    stim_done = 1'b1;
  end

  initial begin : monitor
    while (run) begin
      @(negedge clk);
      cycles++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.msk[0]) begin
          checks++;
          if (I_syn !== e.ei) begin
            failures++;
            $display("FAIL %s I_syn actual=%0d required=%0d", e.nm, $signed(I_syn), $signed(e.ei));
          end
        end
        if (e.msk[1]) begin
          checks++;
          if (sat !== e.es) begin
            failures++;
            $display("FAIL %s sat actual=%b required=%b", e.nm, sat, e.es);
          end
        end
        if (e.msk[2]) begin
          checks++;
          if (spk_ready !== e.er) begin
            failures++;
            $display("FAIL %s spk_ready actual=%b required=%b", e.nm, spk_ready, e.er);
          end
        end
      end else if (stim_done) begin
        run = 1'b0;
      end
      if (run && (cycles > 2000)) begin
        failures++;
        $display("FAIL watchdog cycles actual=%0d required<=2000", cycles);
        run = 1'b0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
